vdp_cpu_port: RTL and testbench
===============================

Name: vdp_cpu_port

Overview:
- CPU-side VDP I/O block: Z80 data port (0xBE) and control port (0xBF), already decoded into strobes.
- Owns the VRAM address register, the two-byte control latch and the read-ahead buffer.
- Writes VRAM and CRAM, writes VDP registers, and fetches VRAM bytes for CPU reads.
- VRAM is shared with the renderers (sprite and background); this block uses only the slots the arbiter grants.

Parameters:
- ADDR_W, 14, VRAM address width; the address wraps modulo 2^ADDR_W.
- CRAM_AW, 5, CRAM address width (32 entries).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_data  in  1  one-cycle strobe: CPU write to the data port
- wr_ctrl  in  1  one-cycle strobe: CPU write to the control port
- rd_data  in  1  one-cycle strobe: CPU read from the data port
- rd_ctrl  in  1  one-cycle strobe: CPU read from the control port
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data (registered)
- cpu_busy  out  1  high while a VRAM operation is pending or in flight
- status_in  in  8  status byte from the timing block
- status_rd  out  1  one-cycle pulse on a status read (clears the frame IRQ flag)
- vram_req  out  1  VRAM access request
- vram_grant  in  1  arbiter grants the current cycle
- vram_addr  out  14  VRAM address
- vram_dout  out  8  VRAM write data
- vram_we  out  1  VRAM write enable
- vram_din  in  8  VRAM read data, valid the cycle after the granted read
- cram_we  out  1  CRAM write pulse
- cram_addr  out  5  CRAM index
- cram_data  out  6  CRAM colour (BBGGRR)
- reg_we  out  1  register write pulse
- reg_num  out  4  register index
- reg_data  out  8  register value

Behaviour:
- Reset values (asynchronous on rst_n low): every output 0, including cpu_dout. Internal state also 0: addr, code, first-byte flag, buffer, FSM = IDLE.
- A reset mid-operation aborts any pending access; no vram_we is issued after rst_n deasserts.
- Strobes are mutually exclusive. Strobes arriving while cpu_busy=1 are ignored and change no state.
- Control port, flag=0:
  - addr[7:0] <= cpu_din.
  - flag <= 1.
- Control port, flag=1:
  - code <= cpu_din[7:6]; addr[13:8] <= cpu_din[5:0]; flag <= 0.
  - code=0: schedule a VRAM read at addr into the buffer; addr <= addr+1.
  - code=2: next cycle, reg_we=1 for one cycle with reg_num=cpu_din[3:0] and reg_data=addr[7:0]. reg_num and reg_data hold until the next register write.
  - code=1 or 3: address setup only.
- rd_data, wr_data and rd_ctrl each clear flag.
- Data port write:
  - buffer <= cpu_din.
  - code=3: next cycle, cram_we pulses with cram_addr=addr[4:0] and cram_data=cpu_din[5:0].
  - Otherwise: schedule a VRAM write of cpu_din at addr.
  - Either way, addr <= addr+1 on the strobe edge.
- Data port read:
  - cpu_dout <= buffer on the strobe edge.
  - Then schedule a read-ahead at addr; addr <= addr+1.
- Control port read:
  - cpu_dout <= status_in.
  - status_rd pulses on the following cycle.
- Address arithmetic: scheduled operations snapshot addr before the increment. addr wraps 0x3FFF -> 0x0000.
- Access FSM:
  - IDLE: when an op is scheduled, go to PEND. vram_req=1, vram_addr = snapshot, cpu_busy=1.
  - PEND: hold until vram_grant=1 is sampled.
    - Write: vram_we=1 and vram_dout valid in the grant cycle; then IDLE.
    - Read: go to RDWAIT.
  - RDWAIT: buffer <= vram_din; back to IDLE. cpu_busy drops in the same cycle the buffer loads.
  - vram_req deasserts in the cycle after the grant.
  - vram_we is never high without vram_grant.
- Latency with the grant held high: write completes 2 cycles after the strobe; read-ahead completes 3 cycles after.
- Grant starvation: the op waits indefinitely with all outputs held stable.

Test Plan:
- Reset: assert rst_n=0 mid-PEND -> all outputs 0 immediately; no vram_we after release; cpu_dout=0.
- VRAM write sequence: ctrl 0x00 then 0x40, data 0xAA, 0x55 with grant held high -> two vram_we cycles at 0x0000/0xAA and 0x0001/0x55; addr ends at 0x0002.
- Read-ahead: VRAM[0x1234]=0x11, [0x1235]=0x22; ctrl 0x34 then 0x12 (code 0) -> a read is issued at 0x1234. First rd_data returns 0x11 and prefetches 0x1235; the second returns 0x22.
- Register and CRAM writes:
  - ctrl 0x0F then 0x87 -> reg_we pulse, reg_num=7, reg_data=0x0F.
  - ctrl 0x1F then 0xC0, then data 0x3F -> cram_we, cram_addr=31, cram_data=0x3F, no vram_we; addr becomes 0x0020.
- Latch reset and wrap:
  - ctrl 0x12, rd_ctrl, ctrl 0xFF then 0x7F -> the second byte pair is decoded as the first pair: addr[7:0]=0xFF, code=1, addr=0x3FFF. status_rd pulses once; cpu_dout=status_in.
  - A following data write lands at 0x3FFF and addr wraps to 0x0000.
- Arbitration/busy: hold vram_grant=0 for 20 cycles after a data write and strobe wr_data again while busy -> second strobe ignored; a single write is issued when the grant arrives; addr incremented once.

Source files
------------

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: Z80 data/control port of the VDP (address register, two-byte control latch, read-ahead buffer).
// Latency: with the grant held, a VRAM write lands 2 cycles after its strobe and a read-ahead completes 3 cycles after.
// Backpressure: cpu_busy is high while a VRAM access is pending or in flight; strobes seen while busy are dropped.
module vdp_cpu_port #(
    parameter int ADDR_W  = 14,
    parameter int CRAM_AW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_data,
    input  logic               wr_ctrl,
    input  logic               rd_data,
    input  logic               rd_ctrl,
    input  logic [7:0]         cpu_din,
    output logic [7:0]         cpu_dout,
    output logic               cpu_busy,
    input  logic [7:0]         status_in,
    output logic               status_rd,
    output logic               vram_req,
    input  logic               vram_grant,
    output logic [ADDR_W-1:0]  vram_addr,
    output logic [7:0]         vram_dout,
    output logic               vram_we,
    input  logic [7:0]         vram_din,
    output logic               cram_we,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [5:0]         cram_data,
    output logic               reg_we,
    output logic [3:0]         reg_num,
    output logic [7:0]         reg_data
);

    localparam int HI_W = ADDR_W - 8;
    localparam logic [ADDR_W-1:0] ADDR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          code_q, code_d;
    logic                flag_q, flag_d;
    logic [7:0]          buf_q;
    logic                op_we_q;
    logic [ADDR_W-1:0]   vram_addr_q;
    logic [7:0]          vram_dout_q;
    logic [7:0]          cpu_dout_q;
    logic                status_rd_q;
    logic                cram_we_q;
    logic [CRAM_AW-1:0]  cram_addr_q;
    logic [5:0]          cram_data_q;
    logic                reg_we_q;
    logic [3:0]          reg_num_q;
    logic [7:0]          reg_data_q;

    logic                busy;
    logic                sched_vld;
    logic                sched_we;
    logic [ADDR_W-1:0]   sched_addr;
    logic [ADDR_W-1:0]   ctl_addr;

    assign busy      = (state_q != ST_IDLE);
    assign cpu_busy  = busy;
    assign vram_req  = (state_q == ST_PEND);
    // The write strobe is gated by the grant so it can never fire in a slot the arbiter gave elsewhere.
    assign vram_we   = (state_q == ST_PEND) && op_we_q && vram_grant;
    assign vram_addr = vram_addr_q;
    assign vram_dout = vram_dout_q;
    assign cpu_dout  = cpu_dout_q;
    assign status_rd = status_rd_q;
    assign cram_we   = cram_we_q;
    assign cram_addr = cram_addr_q;
    assign cram_data = cram_data_q;
    assign reg_we    = reg_we_q;
    assign reg_num   = reg_num_q;
    assign reg_data  = reg_data_q;

    // Decode accepted strobes into next address/code/flag and the VRAM operation to schedule.
    always_comb begin
        addr_d     = addr_q;
        code_d     = code_q;
        flag_d     = flag_q;
        sched_vld  = 1'b0;
        sched_we   = 1'b0;
        sched_addr = addr_q;
        ctl_addr   = {cpu_din[HI_W-1:0], addr_q[7:0]};
        if (!busy) begin
            if (wr_ctrl) begin
                if (!flag_q) begin
                    addr_d = {addr_q[ADDR_W-1:8], cpu_din};
                    flag_d = 1'b1;
                end else begin
                    flag_d = 1'b0;
                    code_d = cpu_din[7:6];
                    addr_d = ctl_addr;
                    if (cpu_din[7:6] == 2'd0) begin
                        // Code 0 primes the read-ahead buffer from the freshly set address.
                        sched_vld  = 1'b1;
                        sched_addr = ctl_addr;
                        addr_d     = ctl_addr + ADDR_INC;
                    end
                end
            end else if (wr_data) begin
                flag_d = 1'b0;
                addr_d = addr_q + ADDR_INC;
                if (code_q != 2'd3) begin
                    sched_vld = 1'b1;
                    sched_we  = 1'b1;
                end
            end else if (rd_data) begin
                flag_d    = 1'b0;
                addr_d    = addr_q + ADDR_INC;
                sched_vld = 1'b1;
            end else if (rd_ctrl) begin
                flag_d = 1'b0;
            end
        end
    end

    // Port registers, side-effect pulses and the VRAM access FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            code_q      <= '0;
            flag_q      <= 1'b0;
            buf_q       <= '0;
            op_we_q     <= 1'b0;
            vram_addr_q <= '0;
            vram_dout_q <= '0;
            cpu_dout_q  <= '0;
            status_rd_q <= 1'b0;
            cram_we_q   <= 1'b0;
            cram_addr_q <= '0;
            cram_data_q <= '0;
            reg_we_q    <= 1'b0;
            reg_num_q   <= '0;
            reg_data_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            code_q      <= code_d;
            flag_q      <= flag_d;
            reg_we_q    <= 1'b0;
            cram_we_q   <= 1'b0;
            status_rd_q <= 1'b0;

            if (!busy) begin
                if (wr_ctrl && flag_q && (cpu_din[7:6] == 2'd2)) begin
                    reg_we_q   <= 1'b1;
                    reg_num_q  <= cpu_din[3:0];
                    reg_data_q <= addr_q[7:0];
                end
                if (wr_data) begin
                    buf_q <= cpu_din;
                    if (code_q == 2'd3) begin
                        cram_we_q   <= 1'b1;
                        cram_addr_q <= addr_q[CRAM_AW-1:0];
                        cram_data_q <= cpu_din[5:0];
                    end
                end
                if (rd_data) begin
                    cpu_dout_q <= buf_q;
                end
                if (rd_ctrl) begin
                    cpu_dout_q  <= status_in;
                    status_rd_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (sched_vld) begin
                        state_q     <= ST_PEND;
                        op_we_q     <= sched_we;
                        vram_addr_q <= sched_addr;
                        if (sched_we) begin
                            vram_dout_q <= cpu_din;
                        end
                    end
                end
                ST_PEND: begin
                    if (vram_grant) begin
                        state_q <= op_we_q ? ST_IDLE : ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    // Read data is valid the cycle after the granted slot.
                    buf_q   <= vram_din;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: directed scenarios plus randomized traffic against a transaction-level model of the port.
// Latency: the bench waits for cpu_busy to drop after each accepted operation.
// Backpressure: vram_grant is held high, held low, or randomized per scenario.
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_data = 1'b0, wr_ctrl = 1'b0, rd_data = 1'b0, rd_ctrl = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_busy;
    logic [7:0]  status_in = '0;
    logic        status_rd;
    logic        vram_req;
    logic        vram_grant = 1'b0;
    logic [13:0] vram_addr;
    logic [7:0]  vram_dout;
    logic        vram_we;
    logic [7:0]  vram_din = '0;
    logic        cram_we;
    logic [4:0]  cram_addr;
    logic [5:0]  cram_data;
    logic        reg_we;
    logic [3:0]  reg_num;
    logic [7:0]  reg_data;

    vdp_cpu_port #(.ADDR_W(14), .CRAM_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data), .wr_ctrl(wr_ctrl), .rd_data(rd_data), .rd_ctrl(rd_ctrl),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
        .status_in(status_in), .status_rd(status_rd),
        .vram_req(vram_req), .vram_grant(vram_grant), .vram_addr(vram_addr),
        .vram_dout(vram_dout), .vram_we(vram_we), .vram_din(vram_din),
        .cram_we(cram_we), .cram_addr(cram_addr), .cram_data(cram_data),
        .reg_we(reg_we), .reg_num(reg_num), .reg_data(reg_data)
    );

    always #5 clk = ~clk;

    localparam int K_WD = 0, K_WC = 1, K_RD = 2, K_RC = 3;

    int n_chk = 0;
    int n_fail = 0;
    int grant_mode = 0;   // 0: held low, 1: held high, 2: random

    logic [7:0] mem     [16384];   // VRAM as seen by the DUT
    logic [7:0] ref_mem [16384];   // VRAM as the model expects it

    // Transaction-level model state
    logic [13:0] m_addr;
    logic [1:0]  m_code;
    logic        m_flag;
    logic [7:0]  m_buf;
    logic [7:0]  m_dout;

    logic [21:0] act_wr[$], exp_wr[$];
    logic [11:0] act_reg[$], exp_reg[$];
    logic [10:0] act_cram[$], exp_cram[$];
    int          act_status = 0, exp_status = 0;

    logic [58:0] outs;
    assign outs = {cpu_dout, cpu_busy, status_rd, vram_req, vram_addr, vram_dout, vram_we,
                   cram_we, cram_addr, cram_data, reg_we, reg_num, reg_data};

    // Arbiter: grant changes shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (grant_mode == 0) vram_grant = 1'b0;
        else if (grant_mode == 1) vram_grant = 1'b1;
        else vram_grant = ($urandom_range(0, 1) == 1);
    end

    // VRAM: writes land on the granted edge; read data appears only in the following cycle.
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_dout;
        if (vram_req && vram_grant && !vram_we) vram_din <= mem[vram_addr];
        else vram_din <= 8'($urandom);
    end

    // Side-effect monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vram_we) begin
                n_chk++;
                if (!(vram_grant && vram_req)) begin
                    n_fail++;
                    $display("FAIL we_without_grant: grant=%0b req=%0b, required both 1", vram_grant, vram_req);
                end
                act_wr.push_back({vram_addr, vram_dout});
            end
            if (reg_we) act_reg.push_back({reg_num, reg_data});
            if (cram_we) act_cram.push_back({cram_addr, cram_data});
            if (status_rd) act_status++;
        end
    end

    function automatic void model_reset();
        m_addr = '0; m_code = '0; m_flag = 1'b0; m_buf = '0; m_dout = '0;
        exp_wr.delete(); exp_reg.delete(); exp_cram.delete(); exp_status = 0;
    endfunction

    function automatic void clear_logs();
        act_wr.delete(); act_reg.delete(); act_cram.delete(); act_status = 0;
        exp_wr.delete(); exp_reg.delete(); exp_cram.delete(); exp_status = 0;
    endfunction

    // Effect of one accepted CPU access, from the port's programming rules.
    function automatic void model_apply(input int kind, input logic [7:0] d);
        case (kind)
            K_WC: begin
                if (!m_flag) begin
                    m_addr[7:0] = d;
                    m_flag = 1'b1;
                end else begin
                    m_flag = 1'b0;
                    m_code = d[7:6];
                    m_addr[13:8] = d[5:0];
                    if (m_code == 2'd0) begin
                        m_buf  = ref_mem[m_addr];
                        m_addr = m_addr + 14'd1;
                    end else if (m_code == 2'd2) begin
                        exp_reg.push_back({d[3:0], m_addr[7:0]});
                    end
                end
            end
            K_WD: begin
                m_flag = 1'b0;
                m_buf  = d;
                if (m_code == 2'd3) begin
                    exp_cram.push_back({m_addr[4:0], d[5:0]});
                end else begin
                    ref_mem[m_addr] = d;
                    exp_wr.push_back({m_addr, d});
                end
                m_addr = m_addr + 14'd1;
            end
            K_RD: begin
                m_flag = 1'b0;
                m_dout = m_buf;
                m_buf  = ref_mem[m_addr];
                m_addr = m_addr + 14'd1;
            end
            default: begin
                m_flag = 1'b0;
                m_dout = status_in;
                exp_status++;
            end
        endcase
    endfunction

    // One strobe cycle; returns on the falling edge just after the strobe was sampled.
    task automatic op(input int kind, input logic [7:0] d, input bit upd);
        @(negedge clk);
        cpu_din = d;
        case (kind)
            K_WD: wr_data = 1'b1;
            K_WC: wr_ctrl = 1'b1;
            K_RD: rd_data = 1'b1;
            default: rd_ctrl = 1'b1;
        endcase
        if (upd) model_apply(kind, d);
        @(negedge clk);
        {wr_data, wr_ctrl, rd_data, rd_ctrl} = 4'b0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!cpu_busy) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        #1;
    endtask

    task automatic poke(input logic [13:0] a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic test_reset();
        n_chk++;
        if (outs !== 59'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
    endtask

    task automatic test_vram_write();
        bit to;
        grant_mode = 1;
        @(negedge clk); @(negedge clk);
        clear_logs();
        op(K_WC, 8'h00, 1); op(K_WC, 8'h40, 1);
        op(K_WD, 8'hAA, 1);
        n_chk++;
        if (!(vram_we === 1'b1 && vram_addr === 14'h0000 && vram_dout === 8'hAA)) begin
            n_fail++;
            $display("FAIL wr_first_cycle: we=%0b addr=%h dout=%h, required 1/0000/aa", vram_we, vram_addr, vram_dout);
        end
        @(negedge clk);
        n_chk++;
        if (cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_latency: busy=%0b two cycles after strobe, required 0", cpu_busy);
        end
        op(K_WD, 8'h55, 1); wait_idle(to);
        op(K_WD, 8'h77, 1); wait_idle(to);
        n_chk++;
        if (to || act_wr.size() != 3) begin
            n_fail++;
            $display("FAIL wr_count: got %0d writes (timeout=%0b), required 3", act_wr.size(), to);
        end else begin
            n_chk++;
            if (act_wr[0] !== {14'h0000, 8'hAA} || act_wr[1] !== {14'h0001, 8'h55} || act_wr[2] !== {14'h0002, 8'h77}) begin
                n_fail++;
                $display("FAIL wr_sequence: got %h %h %h, required 0000aa 000155 000277", act_wr[0], act_wr[1], act_wr[2]);
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        bit to;
        grant_mode = 0;
        @(negedge clk); @(negedge clk);
        clear_logs();
        op(K_WC, 8'h10, 0); op(K_WC, 8'h42, 0);
        op(K_WD, 8'hC3, 0);
        n_chk++;
        if (!(vram_req === 1'b1 && cpu_busy === 1'b1)) begin
            n_fail++;
            $display("FAIL rst_setup_pend: req=%0b busy=%0b, required 1/1", vram_req, cpu_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (outs !== 59'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %h, required 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        grant_mode = 1;
        repeat (10) @(negedge clk);
        wait_idle(to);
        n_chk++;
        if (act_wr.size() != 0 || cpu_dout !== 8'h00 || cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort: writes=%0d dout=%h busy=%0b, required 0/00/0", act_wr.size(), cpu_dout, cpu_busy);
        end
    endtask

    task automatic test_read_ahead();
        bit to;
        grant_mode = 1;
        @(negedge clk); @(negedge clk);
        clear_logs();
        poke(14'h1234, 8'h11);
        poke(14'h1235, 8'h22);
        op(K_WC, 8'h34, 1); op(K_WC, 8'h12, 1);
        n_chk++;
        if (!(vram_req === 1'b1 && vram_addr === 14'h1234 && vram_we === 1'b0)) begin
            n_fail++;
            $display("FAIL ra_issue: req=%0b addr=%h we=%0b, required 1/1234/0", vram_req, vram_addr, vram_we);
        end
        wait_idle(to);
        op(K_RD, 8'h00, 1);
        n_chk++;
        if (!(cpu_dout === 8'h11 && vram_addr === 14'h1235 && cpu_busy === 1'b1)) begin
            n_fail++;
            $display("FAIL ra_first: dout=%h addr=%h busy=%0b, required 11/1235/1", cpu_dout, vram_addr, cpu_busy);
        end
        @(negedge clk);
        n_chk++;
        if (cpu_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ra_latency_hold: busy=%0b, required 1", cpu_busy);
        end
        @(negedge clk);
        n_chk++;
        if (cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ra_latency_done: busy=%0b, required 0", cpu_busy);
        end
        op(K_RD, 8'h00, 1);
        n_chk++;
        if (cpu_dout !== 8'h22) begin
            n_fail++;
            $display("FAIL ra_second: dout=%h, required 22", cpu_dout);
        end
        wait_idle(to);
    endtask

    task automatic test_reg_cram();
        bit to;
        grant_mode = 1;
        clear_logs();
        op(K_WC, 8'h0F, 1); op(K_WC, 8'h87, 1);
        n_chk++;
        if (!(reg_we === 1'b1 && reg_num === 4'd7 && reg_data === 8'h0F)) begin
            n_fail++;
            $display("FAIL reg_write: we=%0b num=%0d data=%h, required 1/7/0f", reg_we, reg_num, reg_data);
        end
        @(negedge clk);
        n_chk++;
        if (!(reg_we === 1'b0 && reg_num === 4'd7 && reg_data === 8'h0F)) begin
            n_fail++;
            $display("FAIL reg_pulse_hold: we=%0b num=%0d data=%h, required 0/7/0f", reg_we, reg_num, reg_data);
        end
        op(K_WC, 8'h1F, 1); op(K_WC, 8'hC0, 1);
        op(K_WD, 8'h3F, 1);
        n_chk++;
        if (!(cram_we === 1'b1 && cram_addr === 5'd31 && cram_data === 6'h3F && vram_req === 1'b0)) begin
            n_fail++;
            $display("FAIL cram_write: we=%0b addr=%0d data=%h req=%0b, required 1/31/3f/0", cram_we, cram_addr, cram_data, vram_req);
        end
        wait_idle(to);
        n_chk++;
        if (act_wr.size() != 0 || act_reg.size() != 1) begin
            n_fail++;
            $display("FAIL cram_no_vram: vram writes=%0d reg writes=%0d, required 0/1", act_wr.size(), act_reg.size());
        end
        op(K_RD, 8'h00, 1);
        n_chk++;
        if (!(vram_req === 1'b1 && vram_addr === 14'h0020)) begin
            n_fail++;
            $display("FAIL cram_addr_inc: req=%0b addr=%h, required 1/0020", vram_req, vram_addr);
        end
        wait_idle(to);
    endtask

    task automatic test_latch_wrap();
        bit to;
        logic [7:0] sval;
        grant_mode = 1;
        clear_logs();
        sval = 8'($urandom);
        status_in = sval;
        op(K_WC, 8'h12, 1);
        op(K_RC, 8'h00, 1);
        n_chk++;
        if (!(status_rd === 1'b1 && cpu_dout === sval)) begin
            n_fail++;
            $display("FAIL status_read: pulse=%0b dout=%h, required 1/%h", status_rd, cpu_dout, sval);
        end
        op(K_WC, 8'hFF, 1); op(K_WC, 8'h7F, 1);
        op(K_WD, 8'h66, 1);
        n_chk++;
        if (!(vram_we === 1'b1 && vram_addr === 14'h3FFF && vram_dout === 8'h66)) begin
            n_fail++;
            $display("FAIL latch_realign: we=%0b addr=%h dout=%h, required 1/3fff/66", vram_we, vram_addr, vram_dout);
        end
        wait_idle(to);
        op(K_WD, 8'h67, 1);
        n_chk++;
        if (!(vram_we === 1'b1 && vram_addr === 14'h0000)) begin
            n_fail++;
            $display("FAIL addr_wrap: we=%0b addr=%h, required 1/0000", vram_we, vram_addr);
        end
        wait_idle(to);
        n_chk++;
        if (act_status != 1) begin
            n_fail++;
            $display("FAIL status_pulse_count: got %0d, required 1", act_status);
        end
    endtask

    task automatic test_busy();
        bit to;
        bit stable;
        grant_mode = 0;
        @(negedge clk); @(negedge clk);
        clear_logs();
        op(K_WC, 8'h00, 1); op(K_WC, 8'h41, 1);
        op(K_WD, 8'h9A, 1);
        repeat (3) @(negedge clk);
        op(K_WD, 8'hBC, 0);   // dropped: port is busy
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!(vram_req === 1'b1 && vram_we === 1'b0 && vram_addr === 14'h0100 &&
                  vram_dout === 8'h9A && cpu_busy === 1'b1)) stable = 1'b0;
            @(negedge clk);
        end
        n_chk++;
        if (!stable) begin
            n_fail++;
            $display("FAIL starve_hold: req=%0b we=%0b addr=%h dout=%h, required 1/0/0100/9a", vram_req, vram_we, vram_addr, vram_dout);
        end
        grant_mode = 1;
        wait_idle(to);
        n_chk++;
        if (to || act_wr.size() != 1) begin
            n_fail++;
            $display("FAIL busy_single: writes=%0d timeout=%0b, required 1/0", act_wr.size(), to);
        end else begin
            n_chk++;
            if (act_wr[0] !== {14'h0100, 8'h9A}) begin
                n_fail++;
                $display("FAIL busy_write: got %h, required 01009a", act_wr[0]);
            end
        end
        op(K_WD, 8'h33, 1);
        n_chk++;
        if (!(vram_addr === 14'h0101 && vram_dout === 8'h33)) begin
            n_fail++;
            $display("FAIL busy_addr_once: addr=%h dout=%h, required 0101/33", vram_addr, vram_dout);
        end
        wait_idle(to);
    endtask

    task automatic test_random();
        bit to;
        int kind;
        logic [7:0] d;
        logic [21:0] a22, e22;
        logic [11:0] a12, e12;
        logic [10:0] a11, e11;
        grant_mode = 2;
        clear_logs();
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 3);
            d = 8'($urandom);
            status_in = 8'($urandom);
            op(kind, d, 1);
            wait_idle(to);
            n_chk++;
            if (to) begin
                n_fail++;
                $display("FAIL rnd_timeout: op %0d still busy, required idle", it);
            end
            if (kind == K_RD || kind == K_RC) begin
                n_chk++;
                if (cpu_dout !== m_dout) begin
                    n_fail++;
                    $display("FAIL rnd_dout: op %0d got %h, required %h", it, cpu_dout, m_dout);
                end
            end
            while (act_wr.size() > 0 || exp_wr.size() > 0) begin
                n_chk++;
                if (act_wr.size() == 0 || exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_vram_count: op %0d got %0d, required %0d", it, act_wr.size(), exp_wr.size());
                    act_wr.delete(); exp_wr.delete();
                end else begin
                    a22 = act_wr.pop_front(); e22 = exp_wr.pop_front();
                    if (a22 !== e22) begin
                        n_fail++;
                        $display("FAIL rnd_vram_write: op %0d got %h, required %h", it, a22, e22);
                    end
                end
            end
            while (act_reg.size() > 0 || exp_reg.size() > 0) begin
                n_chk++;
                if (act_reg.size() == 0 || exp_reg.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_reg_count: op %0d got %0d, required %0d", it, act_reg.size(), exp_reg.size());
                    act_reg.delete(); exp_reg.delete();
                end else begin
                    a12 = act_reg.pop_front(); e12 = exp_reg.pop_front();
                    if (a12 !== e12) begin
                        n_fail++;
                        $display("FAIL rnd_reg_write: op %0d got %h, required %h", it, a12, e12);
                    end
                end
            end
            while (act_cram.size() > 0 || exp_cram.size() > 0) begin
                n_chk++;
                if (act_cram.size() == 0 || exp_cram.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_cram_count: op %0d got %0d, required %0d", it, act_cram.size(), exp_cram.size());
                    act_cram.delete(); exp_cram.delete();
                end else begin
                    a11 = act_cram.pop_front(); e11 = exp_cram.pop_front();
                    if (a11 !== e11) begin
                        n_fail++;
                        $display("FAIL rnd_cram_write: op %0d got %h, required %h", it, a11, e11);
                    end
                end
            end
        end
        n_chk++;
        if (act_status != exp_status) begin
            n_fail++;
            $display("FAIL rnd_status_count: got %0d, required %0d", act_status, exp_status);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_vram_write();
        test_reset_mid_pend();
        test_read_ahead();
        test_reg_cram();
        test_latch_wrap();
        test_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
